// File: rtl/minterm_extractor.sv
// rtl/minterm_extractor.sv - streams the indices of a loaded truth table's minterms or maxterms in ascending order
module minterm_extractor #(
   parameter int N_VARS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   mode,
   input  logic [2**N_VARS-1:0]   table_in,
   output logic                   busy,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [N_VARS-1:0]      m_index,
   output logic                   m_last,
   output logic                   done,
   output logic [N_VARS:0]        count
);

   localparam int TW = 2**N_VARS;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t            state;
   logic [TW-1:0]     tbl;
   logic [TW-1:0]     rem;
   logic [N_VARS-1:0] idx;
   logic              hit;
   logic              last;

   // rem holds the not-yet-visited part of the table; termination is decided
   // from it before idx increments, so idx never wraps past the final index.
   assign rem  = tbl >> idx;
   assign hit  = rem[0];
   assign last = (rem >> 1) == '0;

   // Outputs decode purely from registered state, so m_ready never reaches m_valid
   // and an asynchronous reset clears them at once.
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign m_valid = (state == S_SCAN) && hit;
   assign m_index = idx;
   assign m_last  = m_valid && last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         tbl   <= '0;
         idx   <= '0;
         count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load) begin
                  tbl   <= mode ? ~table_in : table_in;
                  idx   <= '0;
                  count <= '0;
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (rem == '0) begin
                  state <= S_DONE;
               end else if (!hit) begin
                  idx <= idx + 1'b1;
               end else if (m_ready) begin
                  count <= count + 1'b1;
                  if (last) state <= S_DONE;
                  else      idx   <= idx + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_minterm_extractor.sv
// tb/tb_minterm_extractor.sv - vector table plus scoreboard bench for minterm_extractor
module tb_minterm_extractor;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic        mode;
   logic [15:0] table_in;
   logic        busy;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_index;
   logic        m_last;
   logic        done;
   logic [4:0]  count;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   typedef struct {
      logic [15:0] tbl;
      logic        md;
      int          exp_count;
      int          exp_last;
   } vec_t;

   vec_t vecs[8];

   minterm_extractor #(.N_VARS(4)) dut (
      .clk(clk), .reset(reset), .load(load), .mode(mode), .table_in(table_in),
      .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
      .m_last(m_last), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_job(input logic [15:0] t, input logic md, input int exp_cnt,
                          input int exp_last, input bit bp, input bit poke);
      int  done_cyc;
      int  stall;
      bit  prev_st;
      int  prev_idx;
      int  prev_last;
      int  e;
      exp_q.delete();
      for (int k = 0; k < 16; k++)
         if (t[k] ^ md) exp_q.push_back(k);
      @(negedge clk);
      load = 1'b1; table_in = t; mode = md; m_ready = !bp;
      @(posedge clk);
      #1;
      load = 1'b0; table_in = 16'(~t); mode = ~md;
      done_cyc = -1; stall = 0; prev_st = 0; prev_idx = 0; prev_last = 0;
      for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 0) chk("count_start", int'(count), 0);
         if (prev_st) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_index", int'(m_index), prev_idx);
            chk("stall_last", int'(m_last), prev_last);
         end
         if (bp) begin
            if (m_valid && stall < 3) begin m_ready = 1'b0; stall++; end
            else begin m_ready = 1'b1; stall = 0; end
         end else begin
            m_ready = 1'b1;
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_term", int'(m_index), -1);
            else begin
               e = exp_q.pop_front();
               chk("m_index", int'(m_index), e);
               chk("m_last", int'(m_last), int'(exp_q.size() == 0));
            end
         end
         prev_st = m_valid && !m_ready;
         prev_idx = int'(m_index);
         prev_last = int'(m_last);
         if (done) begin
            done_cyc = cyc;
            chk("busy_in_done", int'(busy), 1);
            chk("valid_in_done", int'(m_valid), 0);
         end
         load = poke && (cyc == 4 || done);
         if (load) table_in = 16'hFFFF;
      end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
      chk("final_count", int'(count), exp_cnt);
      chk("terms_left", exp_q.size(), 0);
      if (!bp) chk("done_cycle", done_cyc, (exp_last < 0) ? 1 : exp_last + 1);
      @(negedge clk);
      load = 1'b0;
      chk("done_pulse_once", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("count_hold", int'(count), exp_cnt);
   endtask

   initial begin
      bit found;
      vecs[0] = '{16'h28AB, 1'b0, 7, 13};
      vecs[1] = '{16'h28AB, 1'b1, 9, 15};
      vecs[2] = '{16'h0000, 1'b0, 0, -1};
      vecs[3] = '{16'hFFFF, 1'b1, 0, -1};
      vecs[4] = '{16'hFFFF, 1'b0, 16, 15};
      vecs[5] = '{16'h8000, 1'b0, 1, 15};
      vecs[6] = '{16'h0001, 1'b1, 15, 15};
      vecs[7] = '{16'h0001, 1'b0, 1, 0};

      reset = 1'b1; load = 1'b0; mode = 1'b0; table_in = '0; m_ready = 1'b0;
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_last", int'(m_last), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_index", int'(m_index), 0);
      chk("rst_count", int'(count), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run_job(vecs[i].tbl, vecs[i].md, vecs[i].exp_count, vecs[i].exp_last, 1'b0, 1'b0);

      run_job(16'h28AB, 1'b0, 7, 13, 1'b1, 1'b1);

      @(negedge clk);
      load = 1'b1; table_in = 16'h28AB; mode = 1'b0; m_ready = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      found = 0;
      for (int cyc = 0; cyc < 50 && !found; cyc++) begin
         @(negedge clk);
         if (m_valid && m_index == 4'd5) begin
            m_ready = 1'b0;
            found = 1;
         end
      end
      if (!found) chk("reach_index5_timeout", 0, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", int'(m_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_index", int'(m_index), 0);
      chk("midrst_last", int'(m_last), 0);
      chk("midrst_count", int'(count), 0);
      chk("midrst_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      run_job(16'h28AB, 1'b0, 7, 13, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
